// File: rtl/hs_skid_buffer_if.sv
// Valid/ready/data handshake bundle. The producer side uses the master modport
// and the consumer side uses the slave modport.
interface hs_skid_buffer_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hs_skid_buffer.sv
// Two-entry valid/ready skid buffer. Every output is decoded from flops.
// Define HS_BEAT_CNT_EN to compile in the beat_cnt port and its wrapping counter.
module hs_skid_buffer #(
  parameter int DATA_W = 8
`ifdef HS_BEAT_CNT_EN
  ,
  parameter int CNT_W  = 3
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  hs_skid_buffer_if.slave  s_if,
  hs_skid_buffer_if.master m_if,
`ifdef HS_BEAT_CNT_EN
  output logic [CNT_W-1:0] beat_cnt,
`endif
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              s_fire, m_fire;

  // Reset gates s_ready so that no beat is taken while the buffer is being cleared.
  assign s_if.ready  = ~sys_rst & (state_q != FULL);
  assign m_if.valid  = (state_q != EMPTY);
  assign m_if.data   = main_q;
  assign occupancy   = state_q;

  assign s_fire = s_if.valid & s_if.ready;
  assign m_fire = m_if.valid & m_if.ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (s_fire) begin
          main_d  = s_if.data;
          state_d = ONE;
        end
      end
      ONE: begin
        // A simultaneous accept and release replaces main in place, with no bubble.
        unique case ({s_fire, m_fire})
          2'b10: begin
            skid_d  = s_if.data;
            state_d = FULL;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   main_d  = s_if.data;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (m_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef HS_BEAT_CNT_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q + CNT_W'(m_fire);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: doc/hs_skid_buffer.md
# hs_skid_buffer

Two-entry valid/ready skid buffer (register slice) for the bus-handshake exercises. It sits directly downstream of the valid/ready handshake stage: it accepts beats from that stage and re-presents them to the consumer. Every output is decoded from flops, which breaks the combinational ready path. It sustains one beat per cycle, and an optional counter reports accepted output beats.

## Interface
- DATA_W, 8, beat payload width
- CNT_W, 3, beat counter width; the counter wraps modulo 2^CNT_W
- sys_clk  in  1  system clock; all logic is on the rising edge
- sys_rst  in  1  synchronous reset, active-high
- s_valid  in  1  upstream beat valid
- s_ready  out  1  buffer can accept a beat
- s_data  in  DATA_W  upstream payload
- m_valid  out  1  buffer presents a beat
- m_ready  in  1  downstream accepts the beat
- m_data  out  DATA_W  presented payload
- occupancy  out  2  beats held: 0, 1 or 2
- beat_cnt  out  CNT_W  count of m-side handshakes (present only with HS_BEAT_CNT_EN)

## Operation
- Handshake definitions: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- Storage: main register (drives m_data) and skid register.
- State machine, encoded as occupancy:
  - EMPTY(0): on s_fire, main <= s_data and go to ONE.
  - ONE(1), s_fire only: skid <= s_data and go to FULL.
  - ONE(1), m_fire only: go to EMPTY.
  - ONE(1), s_fire and m_fire together: main <= s_data and stay in ONE.
  - ONE(1), neither: hold.
  - FULL(2), m_fire: main <= skid and go to ONE. s_fire cannot occur in FULL.
- Output decode:
  - m_valid = (state != EMPTY).
  - s_ready = ~sys_rst & (state != FULL).
  - Neither output has a combinational path from s_valid or m_ready.
- Ordering: beats leave in acceptance order, with no loss or duplication.
- Stability: m_valid and m_data hold steady while m_valid & ~m_ready. Upstream must hold s_data steady while s_valid & ~s_ready.
- Data registers: main and skid load only as listed above and are otherwise unchanged.

## Timing
- Reset values (sys_rst high at a clock edge): state EMPTY, m_valid 0, m_data 0, skid 0, occupancy 0, beat_cnt 0.
- s_ready is 0 during any cycle with sys_rst high and is 1 from the first cycle after reset release.
- Reset mid-operation: any held beats are discarded. A pending m-side beat is not counted.
- Latency: s_fire in cycle N gives m_valid=1 with that data in cycle N+1.
- Throughput: with m_ready held at 1, one beat per cycle; occupancy stays at 1.
- Backpressure:
  - m_ready low while in ONE: one more beat is absorbed and the buffer goes to FULL.
  - s_ready drops in the cycle after reaching FULL.
  - s_ready returns in the cycle after the FULL→ONE m_fire.
- Simultaneous events: s_fire and m_fire in ONE replace main in place, with no bubble.
- beat_cnt increments by 1 in the cycle after each m_fire and wraps from 2^CNT_W−1 to 0.

## Configuration
- HS_BEAT_CNT_EN defined:
  - beat_cnt port and its CNT_W counter are compiled in.
  - The counter counts m_fire events and wraps.
- HS_BEAT_CNT_EN undefined:
  - beat_cnt port and counter are absent.
  - CNT_W is unused.
  - Datapath behaviour is identical in both builds.

## Test plan
- Reset: sys_rst=1 for 2 cycles with s_valid=1 → s_ready=0, m_valid=0, m_data=0, occupancy=0. First cycle after release → s_ready=1.
- Streaming: m_ready=1, send 0x11,0x22,0x33 back-to-back → m_data is 0x11,0x22,0x33 on three consecutive cycles, each one cycle after its s_fire. Occupancy stays 1. beat_cnt=3.
- Skid fill: m_ready=0, send 0xA0,0xA1 → occupancy 2, s_ready=0, m_data holds 0xA0. Raise m_ready → 0xA0 then 0xA1 delivered. s_ready is 1 again one cycle after the first m_fire.
- Simultaneous: in ONE holding 0x55, s_fire with 0x66 and m_fire in the same cycle → next cycle m_data=0x66, occupancy=1.
- Wrap: 9 m_fires with CNT_W=3 → beat_cnt reads 1.
- Reset mid-operation: in FULL, assert sys_rst for 1 cycle → occupancy 0, m_valid 0. The held beats never appear on m_data.
